// File: rtl/wb_dev_master_pkg.sv
// Shared constants for the Wishbone development master: FSM encodings and default abort timeout.
`ifndef WB_DEV_MASTER_DEFINES
`define WB_DEV_MASTER_DEFINES
`define WBDM_ST_IDLE         2'd0
`define WBDM_ST_BUS          2'd1
`define WBDM_ST_DONE         2'd2
`define WBDM_TIMEOUT_DEFAULT 255
`endif

package wb_dev_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = `WBDM_ST_IDLE,
    ST_BUS  = `WBDM_ST_BUS,
    ST_DONE = `WBDM_ST_DONE
  } wbdm_state_t;

endpackage

// File: rtl/wb_dev_master.sv
// Single-transaction Wishbone classic master: one request in, one bus cycle out,
// one-cycle response pulse back, with a bounded wait for ACK.
module wb_dev_master
  import wb_dev_master_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int TIMEOUT   = `WBDM_TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_i,
  input  logic [ADDR_BITS-1:2]   req_addr_i,
  input  logic [3:0]             req_sel_i,
  input  logic                   req_we_i,
  input  logic [31:0]            req_data_i,
  output logic                   req_busy_o,
  output logic                   resp_valid_o,
  output logic [31:0]            resp_data_o,
  output logic                   resp_err_o,
  output logic                   wbm_cyc_o,
  output logic                   wbm_stb_o,
  output logic [ADDR_BITS-1:2]   wbm_addr_o,
  output logic [3:0]             wbm_sel_o,
  output logic                   wbm_we_o,
  output logic [31:0]            wbm_data_o,
  input  logic [31:0]            wbm_data_i,
  input  logic                   wbm_ack_i
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  wbdm_state_t r_state;
  logic [7:0]  r_count;

  // ACK is checked before the timeout so a late ACK on the final wait cycle still completes cleanly.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_count      <= 8'd0;
      req_busy_o   <= 1'b0;
      resp_valid_o <= 1'b0;
      resp_data_o  <= 32'd0;
      resp_err_o   <= 1'b0;
      wbm_cyc_o    <= 1'b0;
      wbm_stb_o    <= 1'b0;
      wbm_addr_o   <= '0;
      wbm_sel_o    <= 4'd0;
      wbm_we_o     <= 1'b0;
      wbm_data_o   <= 32'd0;
    end else begin
      resp_valid_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_i) begin
            wbm_addr_o <= req_addr_i;
            wbm_sel_o  <= req_sel_i;
            wbm_we_o   <= req_we_i;
            wbm_data_o <= req_data_i;
            wbm_cyc_o  <= 1'b1;
            wbm_stb_o  <= 1'b1;
            r_count    <= 8'd0;
            req_busy_o <= 1'b1;
            r_state    <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (wbm_ack_i) begin
            if (!wbm_we_o) begin
              resp_data_o <= wbm_data_i;
            end
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_valid_o <= 1'b1;
            r_state      <= ST_DONE;
          end else if (r_count == TIMEOUT_LAST) begin
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            resp_err_o   <= 1'b1;
            resp_data_o  <= 32'd0;
            resp_valid_o <= 1'b1;
            r_state      <= ST_DONE;
          end else begin
            r_count <= r_count + 8'd1;
          end
        end
        ST_DONE: begin
          req_busy_o <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          req_busy_o <= 1'b0;
          wbm_cyc_o  <= 1'b0;
          wbm_stb_o  <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_dev_master.sv
// Directed bench for wb_dev_master with a short timeout so abort paths are reachable quickly.
module tb_wb_dev_master;

  localparam int ADDR_BITS = 16;
  localparam int TIMEOUT   = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 req_i;
  logic [ADDR_BITS-1:2] req_addr_i;
  logic [3:0]           req_sel_i;
  logic                 req_we_i;
  logic [31:0]          req_data_i;
  logic                 req_busy_o;
  logic                 resp_valid_o;
  logic [31:0]          resp_data_o;
  logic                 resp_err_o;
  logic                 wbm_cyc_o;
  logic                 wbm_stb_o;
  logic [ADDR_BITS-1:2] wbm_addr_o;
  logic [3:0]           wbm_sel_o;
  logic                 wbm_we_o;
  logic [31:0]          wbm_data_o;
  logic [31:0]          wbm_data_i;
  logic                 wbm_ack_i;

  int testsRun    = 0;
  int testsFailed = 0;
  int stbCount;
  int validCount;

  wb_dev_master #(.ADDR_BITS(ADDR_BITS), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .req_addr_i   (req_addr_i),
    .req_sel_i    (req_sel_i),
    .req_we_i     (req_we_i),
    .req_data_i   (req_data_i),
    .req_busy_o   (req_busy_o),
    .resp_valid_o (resp_valid_o),
    .resp_data_o  (resp_data_o),
    .resp_err_o   (resp_err_o),
    .wbm_cyc_o    (wbm_cyc_o),
    .wbm_stb_o    (wbm_stb_o),
    .wbm_addr_o   (wbm_addr_o),
    .wbm_sel_o    (wbm_sel_o),
    .wbm_we_o     (wbm_we_o),
    .wbm_data_o   (wbm_data_o),
    .wbm_data_i   (wbm_data_i),
    .wbm_ack_i    (wbm_ack_i)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns so both driving and sampling happen away from the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [ADDR_BITS-1:2] addr,
                               input logic [3:0] sel, input logic we, input logic [31:0] data);
    req_i      = req;
    req_addr_i = addr;
    req_sel_i  = sel;
    req_we_i   = we;
    req_data_i = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  initial begin
    rst        = 1'b1;
    wbm_ack_i  = 1'b0;
    wbm_data_i = 32'd0;
    applyStimulus(1'b0, '0, 4'h0, 1'b0, 32'd0);
    tick(3);
    rst = 1'b0;
    checkOutput("reset_cyc",   {31'd0, wbm_cyc_o},    32'd0);
    checkOutput("reset_stb",   {31'd0, wbm_stb_o},    32'd0);
    checkOutput("reset_busy",  {31'd0, req_busy_o},   32'd0);
    checkOutput("reset_valid", {31'd0, resp_valid_o}, 32'd0);
    checkOutput("reset_rdata", resp_data_o,           32'd0);
    checkOutput("reset_addr",  {18'd0, wbm_addr_o},   32'd0);
    checkOutput("reset_wdata", wbm_data_o,            32'd0);

    // Write to byte address 0x0104, ACK on the second strobe cycle, with a stray request while busy.
    applyStimulus(1'b1, 14'h0041, 4'hF, 1'b1, 32'hDEADBEEF);
    tick();
    applyStimulus(1'b1, 14'h07FF, 4'h1, 1'b0, 32'h11111111);
    checkOutput("wr_stb1",   {31'd0, wbm_stb_o},  32'd1);
    checkOutput("wr_cyc1",   {31'd0, wbm_cyc_o},  32'd1);
    checkOutput("wr_busy",   {31'd0, req_busy_o}, 32'd1);
    checkOutput("wr_addr1",  {18'd0, wbm_addr_o}, 32'h41);
    checkOutput("wr_data1",  wbm_data_o,          32'hDEADBEEF);
    checkOutput("wr_we1",    {31'd0, wbm_we_o},   32'd1);
    tick();
    applyStimulus(1'b0, '0, 4'h0, 1'b0, 32'd0);
    wbm_ack_i  = 1'b1;
    wbm_data_i = 32'hCAFEF00D;
    checkOutput("wr_stb2",   {31'd0, wbm_stb_o},  32'd1);
    checkOutput("wr_addr2",  {18'd0, wbm_addr_o}, 32'h41);
    checkOutput("wr_sel2",   {28'd0, wbm_sel_o},  32'hF);
    checkOutput("wr_data2",  wbm_data_o,          32'hDEADBEEF);
    checkOutput("wr_we2",    {31'd0, wbm_we_o},   32'd1);
    tick();
    wbm_ack_i = 1'b0;
    checkOutput("wr_valid",  {31'd0, resp_valid_o}, 32'd1);
    checkOutput("wr_err",    {31'd0, resp_err_o},   32'd0);
    checkOutput("wr_stb_lo", {31'd0, wbm_stb_o},    32'd0);
    checkOutput("wr_rdata",  resp_data_o,           32'd0);
    checkOutput("wr_busy_d", {31'd0, req_busy_o},   32'd1);
    tick();
    checkOutput("wr_valid_off", {31'd0, resp_valid_o}, 32'd0);
    checkOutput("wr_idle_busy", {31'd0, req_busy_o},   32'd0);

    // Read with ACK on the first strobe cycle.
    applyStimulus(1'b1, 14'h0010, 4'h3, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, '0, 4'h0, 1'b0, 32'd0);
    wbm_ack_i  = 1'b1;
    wbm_data_i = 32'h12345678;
    checkOutput("rd_stb",   {31'd0, wbm_stb_o}, 32'd1);
    checkOutput("rd_sel",   {28'd0, wbm_sel_o}, 32'h3);
    checkOutput("rd_we",    {31'd0, wbm_we_o},  32'd0);
    tick();
    wbm_ack_i = 1'b0;
    checkOutput("rd_valid", {31'd0, resp_valid_o}, 32'd1);
    checkOutput("rd_err",   {31'd0, resp_err_o},   32'd0);
    checkOutput("rd_data",  resp_data_o,           32'h12345678);
    tick();
    checkOutput("rd_valid_off", {31'd0, resp_valid_o}, 32'd0);

    // No ACK: strobe must stay up exactly TIMEOUT cycles, then an error completion.
    applyStimulus(1'b1, 14'h0020, 4'hF, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, '0, 4'h0, 1'b0, 32'd0);
    for (int i = 0; i < TIMEOUT; i++) begin
      checkOutput($sformatf("to_stb%0d", i), {31'd0, wbm_stb_o}, 32'd1);
      checkOutput($sformatf("to_novalid%0d", i), {31'd0, resp_valid_o}, 32'd0);
      tick();
    end
    checkOutput("to_stb_lo", {31'd0, wbm_stb_o},    32'd0);
    checkOutput("to_cyc_lo", {31'd0, wbm_cyc_o},    32'd0);
    checkOutput("to_valid",  {31'd0, resp_valid_o}, 32'd1);
    checkOutput("to_err",    {31'd0, resp_err_o},   32'd1);
    checkOutput("to_rdata",  resp_data_o,           32'd0);
    tick();

    // ACK arriving on the last permitted strobe cycle completes normally.
    applyStimulus(1'b1, 14'h0030, 4'hF, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, '0, 4'h0, 1'b0, 32'd0);
    tick(TIMEOUT - 1);
    checkOutput("late_stb", {31'd0, wbm_stb_o}, 32'd1);
    wbm_ack_i  = 1'b1;
    wbm_data_i = 32'hA5A50F0F;
    tick();
    wbm_ack_i = 1'b0;
    checkOutput("late_valid", {31'd0, resp_valid_o}, 32'd1);
    checkOutput("late_err",   {31'd0, resp_err_o},   32'd0);
    checkOutput("late_data",  resp_data_o,           32'hA5A50F0F);
    tick();

    // ACK while idle has no effect.
    wbm_ack_i  = 1'b1;
    wbm_data_i = 32'hFFFFFFFF;
    tick(2);
    checkOutput("idle_ack_valid", {31'd0, resp_valid_o}, 32'd0);
    checkOutput("idle_ack_data",  resp_data_o,           32'hA5A50F0F);
    checkOutput("idle_ack_stb",   {31'd0, wbm_stb_o},    32'd0);
    wbm_ack_i = 1'b0;

    // Request and ACK held high: one bus cycle and one response every three cycles.
    stbCount   = 0;
    validCount = 0;
    applyStimulus(1'b1, 14'h0050, 4'hF, 1'b0, 32'h0);
    wbm_ack_i  = 1'b1;
    wbm_data_i = 32'h00C0FFEE;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (wbm_stb_o)    stbCount++;
      if (resp_valid_o) validCount++;
      checkOutput($sformatf("bb_cyc_eq_stb%0d", i), {31'd0, wbm_cyc_o}, {31'd0, wbm_stb_o});
    end
    applyStimulus(1'b0, '0, 4'h0, 1'b0, 32'd0);
    wbm_ack_i = 1'b0;
    checkOutput("bb_stb_count",   stbCount,   32'd3);
    checkOutput("bb_valid_count", validCount, 32'd3);
    checkOutput("bb_rdata",       resp_data_o, 32'h00C0FFEE);
    tick();
    checkOutput("bb_idle", {31'd0, req_busy_o}, 32'd0);

    // Reset in the second bus cycle drops the cycle silently; the next request still works.
    applyStimulus(1'b1, 14'h0060, 4'hF, 1'b1, 32'h55AA55AA);
    tick();
    applyStimulus(1'b0, '0, 4'h0, 1'b0, 32'd0);
    tick();
    checkOutput("rst_bus_stb", {31'd0, wbm_stb_o}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_stb",   {31'd0, wbm_stb_o},    32'd0);
    checkOutput("rst_cyc",   {31'd0, wbm_cyc_o},    32'd0);
    checkOutput("rst_valid", {31'd0, resp_valid_o}, 32'd0);
    checkOutput("rst_busy",  {31'd0, req_busy_o},   32'd0);
    checkOutput("rst_rdata", resp_data_o,           32'd0);
    tick();
    checkOutput("rst_valid_after", {31'd0, resp_valid_o}, 32'd0);
    applyStimulus(1'b1, 14'h0070, 4'hC, 1'b0, 32'h0);
    tick();
    applyStimulus(1'b0, '0, 4'h0, 1'b0, 32'd0);
    checkOutput("post_rst_addr", {18'd0, wbm_addr_o}, 32'h70);
    wbm_ack_i  = 1'b1;
    wbm_data_i = 32'h0BADF00D;
    tick();
    wbm_ack_i = 1'b0;
    checkOutput("post_rst_valid", {31'd0, resp_valid_o}, 32'd1);
    checkOutput("post_rst_data",  resp_data_o,           32'h0BADF00D);
    tick();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
